// File: rtl/cmd_debounce_pkg.sv
// Shared definitions for the SET/CLR button conditioner: channel state encodings and synchroniser depth.
package cmd_debounce_pkg;

  // Bit 1 of the encoding is the debounced level, so deb comes straight off a flop.
  localparam logic [1:0] IDLE       = 2'b00;
  localparam logic [1:0] CONF_PRESS = 2'b01;
  localparam logic [1:0] PRESSED    = 2'b11;
  localparam logic [1:0] CONF_REL   = 2'b10;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/cmd_debounce_ch.sv
// One button channel: synchroniser, then a confirm-count FSM that outputs the debounced level.
// Latency: DB_CYCLES+2 edges from first raw sample to deb. No backpressure; free-running.
module debounce_ch
  import cmd_debounce_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic deb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [1:0]             state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:       if (sync) state_nxt = CONF_PRESS;
      CONF_PRESS: begin
        if (!sync)                 state_nxt = IDLE;
        else if (cnt == CNT_LAST)  state_nxt = PRESSED;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      PRESSED:    if (!sync) state_nxt = CONF_REL;
      CONF_REL:   begin
        if (sync)                  state_nxt = PRESSED;
        else if (cnt == CNT_LAST)  state_nxt = IDLE;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      default:    state_nxt = IDLE;
    endcase
    // Any bounce or acceptance restarts the confirmation window.
    if (state_nxt != state) cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign deb = state[1];

endmodule

// File: rtl/cmd_debounce.sv
// SET/CLR button conditioner for the Gray counter; CLR wins, outputs never both high. CMD_PULSE_EN selects pulse mode.
// Latency: DB_CYCLES+3 edges raw-to-output. No backpressure; outputs are registered levels (or 1-cycle pulses).
module cmd_debounce
  import cmd_debounce_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic set_btn,
  input  logic clr_btn,
  output logic set_out,
  output logic clr_out
);

  logic set_deb, clr_deb;

  debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_set_ch (
    .clk   (clk),
    .reset (reset),
    .btn   (set_btn),
    .deb   (set_deb)
  );

  debounce_ch #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_clr_ch (
    .clk   (clk),
    .reset (reset),
    .btn   (clr_btn),
    .deb   (clr_deb)
  );

`ifdef CMD_PULSE_EN
  logic set_deb_q, clr_deb_q;

  // A set edge masked by an active CLR is lost, not deferred.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_deb_q <= 1'b0;
      clr_deb_q <= 1'b0;
      set_out   <= 1'b0;
      clr_out   <= 1'b0;
    end else begin
      set_deb_q <= set_deb;
      clr_deb_q <= clr_deb;
      clr_out   <= clr_deb & ~clr_deb_q;
      set_out   <= set_deb & ~set_deb_q & ~clr_deb;
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_out <= 1'b0;
      clr_out <= 1'b0;
    end else begin
      clr_out <= clr_deb;
      set_out <= set_deb & ~clr_deb;
    end
  end
`endif

endmodule

// File: tb/tb_cmd_debounce.sv
// Bench for cmd_debounce: reset sequences, vector table (level mode) or pulse sequences (CMD_PULSE_EN).
module tb_cmd_debounce;

`ifdef CMD_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, set_btn, clr_btn;
  logic set_out, clr_out;
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;

  typedef struct {
    logic set_btn;
    logic clr_btn;
    logic exp_set;
    logic exp_clr;
  } vec_t;

  typedef struct {
    logic exp_set;
    logic exp_clr;
    int   idx;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  cmd_debounce #(.DB_CYCLES(4), .CNT_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .set_btn (set_btn),
    .clr_btn (clr_btn),
    .set_out (set_out),
    .clr_out (clr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic as, input logic ac,
                       input logic es, input logic ec);
    checks++;
    if (as !== es || ac !== ec) begin
      failures++;
      $display("FAIL %s[%0d]: got set_out=%b clr_out=%b, want set_out=%b clr_out=%b",
               name, idx, as, ac, es, ec);
    end
  endtask

  // Called at a negedge: drive, let one posedge pass, compare at the next negedge.
  task automatic step(input logic s, input logic c, input logic es, input logic ec);
    exp_t e;
    set_btn = s;
    clr_btn = c;
    exp_q.push_back('{exp_set: es, exp_clr: ec, idx: step_no});
    step_no++;
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("step", e.idx, set_out, clr_out, e.exp_set, e.exp_clr);
  endtask

  task automatic seg(input logic s, input logic c, input int n, input logic es, input logic ec);
    for (int k = 0; k < n; k++) vecs.push_back('{set_btn: s, clr_btn: c, exp_set: es, exp_clr: ec});
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if (set_out === 1'b1 && clr_out === 1'b1) begin
        failures++;
        $display("FAIL exclusive: set_out=1 and clr_out=1 at time %0t", $time);
      end
    end
  end

  initial begin
    reset   = 1'b0;
    set_btn = 1'b0;
    clr_btn = 1'b0;
    #12;
    check("reset_state", 0, set_out, clr_out, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Full press, then asynchronous reset while the output is high.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("press_before_reset", 0, set_out, clr_out, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 check("async_reset_drop", 0, set_out, clr_out, 1'b0, 1'b0);
    @(negedge clk);
    set_btn = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-count: the next press must take the full latency again.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1 check("reset_midcount", 0, set_out, clr_out, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("reset_held", 0, set_out, clr_out, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, !PULSE, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, !PULSE, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

`ifndef CMD_PULSE_EN
    // Clean press and release.
    seg(1, 0, 7, 0, 0);  seg(1, 0, 13, 1, 0);
    seg(0, 0, 7, 1, 0);  seg(0, 0, 5, 0, 0);
    // CLR bounce 1,1,0,1,1,1,0, then held.
    seg(0, 1, 2, 0, 0);  seg(0, 0, 1, 0, 0);
    seg(0, 1, 3, 0, 0);  seg(0, 0, 1, 0, 0);
    seg(0, 1, 7, 0, 0);  seg(0, 1, 5, 0, 1);
    seg(0, 0, 7, 0, 1);  seg(0, 0, 5, 0, 0);
    // Both together: CLR wins; releasing CLR lets SET through one edge after clr_deb falls.
    seg(1, 1, 7, 0, 0);  seg(1, 1, 10, 0, 1);
    seg(1, 0, 7, 0, 1);  seg(1, 0, 5, 1, 0);
    seg(0, 0, 7, 1, 0);  seg(0, 0, 5, 0, 0);
    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].set_btn, vecs[i].clr_btn, vecs[i].exp_set, vecs[i].exp_clr);
`else
    // Held SET: exactly one pulse, at the nominal latency.
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, (i == 7), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    // Both pressed together: only CLR pulses.
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0, (i == 7));
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
`endif

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
